// File: rtl/eth_tx_framer_if.sv
// eth_tx_framer client/stream bundle.
// master = framer side, slave = clients plus downstream MAC.
interface eth_tx_framer_if #(
  parameter int NUM_CH = 2
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    REQ_VLD;
  logic [NUM_CH*48-1:0] REQ_DST_MAC;
  logic [NUM_CH*16-1:0] REQ_ETHERTYPE;
  logic [NUM_CH-1:0]    REQ_DONE;
  logic [NUM_CH-1:0]    CH_EN;
  logic [NUM_CH*8-1:0]  CH_DATA;
  logic [NUM_CH-1:0]    CH_LAST;
  logic [7:0]           OUT_DATA;
  logic                 OUT_DATA_VLD;
  logic                 OUT_LAST;
  logic [CW-1:0]        OUT_CH;
  logic                 OUT_TRUNC;

  modport master (
    input  REQ_VLD,
    input  REQ_DST_MAC,
    input  REQ_ETHERTYPE,
    input  CH_DATA,
    input  CH_LAST,
    output REQ_DONE,
    output CH_EN,
    output OUT_DATA,
    output OUT_DATA_VLD,
    output OUT_LAST,
    output OUT_CH,
    output OUT_TRUNC
  );

  modport slave (
    output REQ_VLD,
    output REQ_DST_MAC,
    output REQ_ETHERTYPE,
    output CH_DATA,
    output CH_LAST,
    input  REQ_DONE,
    input  CH_EN,
    input  OUT_DATA,
    input  OUT_DATA_VLD,
    input  OUT_LAST,
    input  OUT_CH,
    input  OUT_TRUNC
  );
endinterface

// File: rtl/eth_tx_framer.sv
// Multi-channel Ethernet TX framer.
// Round-robin grant, header insert, payload pad/truncate.
module eth_tx_framer #(
  parameter logic [47:0] SRC_MAC     = 48'h000A35000001,
  parameter int          NUM_CH      = 2,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter bit          VLAN_EN     = 1'b0,
  parameter logic [15:0] VLAN_TCI    = 16'h0000
) (
  input logic            CLK,
  input logic            RST,
  eth_tx_framer_if.master bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HL = VLAN_EN ? 18 : 14;
  localparam int HW = HL * 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PAD,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] gch;
  logic [HW-1:0] hdr_sr;
  logic [4:0]    hcnt;
  logic [10:0]   pcnt;
  logic [10:0]   pcnt_nx;

  logic              any_req;
  logic [CW-1:0]     pick;
  logic [47:0]       dst_sel;
  logic [15:0]       et_sel;
  logic [HW-1:0]     hdr_init;
  logic [7:0]        dat_g;
  logic              last_g;
  logic [NUM_CH-1:0] gsel;

  function automatic logic [CW-1:0] rr_idx(
    input logic [CW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CW'(s);
  endfunction

  assign pcnt_nx = pcnt + 11'd1;

  // first requester at or after the pointer, wrapping
  always_comb begin
    any_req = 1'b0;
    pick    = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.REQ_VLD[rr_idx(ptr, i)]) begin
        any_req = 1'b1;
        pick    = rr_idx(ptr, i);
      end
    end
  end

  // channel muxes: header fields of the pick, payload of the grant
  always_comb begin
    dst_sel = '0;
    et_sel  = '0;
    dat_g   = 8'h00;
    last_g  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick == CW'(i)) begin
        dst_sel = bus.REQ_DST_MAC[i*48 +: 48];
        et_sel  = bus.REQ_ETHERTYPE[i*16 +: 16];
      end
      if (gch == CW'(i)) begin
        dat_g  = bus.CH_DATA[i*8 +: 8];
        last_g = bus.CH_LAST[i];
      end
    end
  end

  // one-hot of the granted channel for CH_EN / REQ_DONE
  always_comb begin
    gsel      = '0;
    gsel[gch] = 1'b1;
  end

  if (VLAN_EN) begin : g_vlan
    assign hdr_init = {dst_sel, SRC_MAC, 8'h81, 8'h00, VLAN_TCI, et_sel};
  end else begin : g_plain
    assign hdr_init = {dst_sel, SRC_MAC, et_sel};
  end

  // framer FSM; header is latched whole at grant and shifted out
  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      ptr              <= '0;
      gch              <= '0;
      hdr_sr           <= '0;
      hcnt             <= '0;
      pcnt             <= '0;
      bus.OUT_DATA     <= 8'h00;
      bus.OUT_DATA_VLD <= 1'b0;
      bus.OUT_LAST     <= 1'b0;
      bus.OUT_CH       <= '0;
      bus.OUT_TRUNC    <= 1'b0;
      bus.CH_EN        <= '0;
      bus.REQ_DONE     <= '0;
    end else begin
      bus.CH_EN     <= '0;
      bus.REQ_DONE  <= '0;
      bus.OUT_LAST  <= 1'b0;
      bus.OUT_TRUNC <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.OUT_DATA_VLD <= 1'b0;
          bus.OUT_DATA     <= 8'h00;
          if (any_req) begin
            gch        <= pick;
            bus.OUT_CH <= pick;
            hdr_sr     <= hdr_init;
            hcnt       <= '0;
            state      <= HDR;
          end
        end
        HDR: begin
          bus.OUT_DATA_VLD <= 1'b1;
          bus.OUT_DATA     <= hdr_sr[HW-1 -: 8];
          hdr_sr           <= hdr_sr << 8;
          hcnt             <= hcnt + 5'd1;
          if (hcnt == 5'(HL - 2)) begin
            bus.CH_EN <= gsel;
          end
          if (hcnt == 5'(HL - 1)) begin
            pcnt  <= '0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          bus.OUT_DATA <= dat_g;
          pcnt         <= pcnt_nx;
          if (last_g) begin
            if (pcnt_nx >= 11'(MIN_PAYLOAD)) begin
              bus.OUT_LAST <= 1'b1;
              state        <= DONE;
            end else begin
              state <= PAD;
            end
          end else if (pcnt_nx == 11'(MAX_PAYLOAD)) begin
            bus.OUT_LAST  <= 1'b1;
            bus.OUT_TRUNC <= 1'b1;
            state         <= DONE;
          end
        end
        PAD: begin
          bus.OUT_DATA <= 8'h00;
          pcnt         <= pcnt_nx;
          if (pcnt_nx >= 11'(MIN_PAYLOAD)) begin
            bus.OUT_LAST <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.OUT_DATA_VLD <= 1'b0;
          bus.OUT_DATA     <= 8'h00;
          bus.REQ_DONE     <= gsel;
          ptr              <= rr_idx(gch, 1);
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// eth_tx_framer bench: directed frames on a plain and a VLAN instance.
// Expected bytes are built from the frame definition.
module tb_eth_tx_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_tx_framer_if #(.NUM_CH(2)) ifa ();
  eth_tx_framer_if #(.NUM_CH(2)) ifb ();

  eth_tx_framer #(
    .NUM_CH(2)
  ) dut_a (
    .CLK(clk),
    .RST(rst),
    .bus(ifa.master)
  );

  eth_tx_framer #(
    .NUM_CH(2),
    .VLAN_EN(1'b1),
    .VLAN_TCI(16'h6005)
  ) dut_b (
    .CLK(clk),
    .RST(rst),
    .bus(ifb.master)
  );

  logic [1:0]  req_a, req_b;
  logic [95:0] dst;
  logic [31:0] et;
  logic [15:0] chd;
  logic [1:0]  chl;
  logic        sel;

  assign ifa.REQ_VLD       = req_a;
  assign ifa.REQ_DST_MAC   = dst;
  assign ifa.REQ_ETHERTYPE = et;
  assign ifa.CH_DATA       = chd;
  assign ifa.CH_LAST       = chl;
  assign ifb.REQ_VLD       = req_b;
  assign ifb.REQ_DST_MAC   = dst;
  assign ifb.REQ_ETHERTYPE = et;
  assign ifb.CH_DATA       = chd;
  assign ifb.CH_LAST       = chl;

  logic [7:0] o_data;
  logic       o_vld, o_last, o_trunc, o_ch;
  logic [1:0] o_en, o_done;
  assign o_data  = sel ? ifb.OUT_DATA     : ifa.OUT_DATA;
  assign o_vld   = sel ? ifb.OUT_DATA_VLD : ifa.OUT_DATA_VLD;
  assign o_last  = sel ? ifb.OUT_LAST     : ifa.OUT_LAST;
  assign o_trunc = sel ? ifb.OUT_TRUNC    : ifa.OUT_TRUNC;
  assign o_ch    = sel ? ifb.OUT_CH       : ifa.OUT_CH;
  assign o_en    = sel ? ifb.CH_EN        : ifa.CH_EN;
  assign o_done  = sel ? ifb.REQ_DONE     : ifa.REQ_DONE;

  int checks, errors;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         last_idx, trunc_idx, done_dly, pre, gaps, en_idx, last_cyc;
  logic [1:0] done_val, en_val;
  logic       och;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic build_exp(input logic [47:0] d, input logic [15:0] e,
                           input bit vl, input int len, input bit has_last);
    logic [47:0] src;
    int n;
    src = 48'h000A35000001;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(d[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(src[8*(5-i) +: 8]);
    if (vl) begin
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h60);
      exp_q.push_back(8'h05);
    end
    exp_q.push_back(e[15:8]);
    exp_q.push_back(e[7:0]);
    n = has_last ? len : 1500;
    if (n > 1500) n = 1500;
    for (int k = 0; k < n; k++) exp_q.push_back(8'(k + 1));
    for (int k = n; k < 46; k++) exp_q.push_back(8'h00);
  endtask

  // client model + output capture for one frame on channel ch
  task automatic run_frame(input int ch, input int len, input bit has_last,
                           input bit scramble, input int abort_at);
    int k, cyc;
    bit fin, started, scr;
    got_q.delete();
    last_idx = -1; trunc_idx = -1; done_dly = -1; pre = 0; gaps = 0;
    en_idx = -1; done_val = 0; en_val = 0; och = 0; last_cyc = 0;
    k = -1; cyc = 0; fin = 0; started = 0; scr = 0;
    while (!fin && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      chd = 16'hEEEE;
      chl = 2'b11;
      chd[8*ch +: 8] = (k >= 0 && k < len) ? 8'(k + 1) : 8'h00;
      chl[ch] = (k >= 0 && k < len && has_last && k == len - 1);
      if (k >= 0) k++;
      if (o_vld) begin
        started = 1;
        och = o_ch;
        got_q.push_back(o_data);
        if (o_last && last_idx < 0) begin
          last_idx = got_q.size() - 1;
          last_cyc = cyc;
        end
        if (o_trunc) trunc_idx = got_q.size() - 1;
      end else if (!started) begin
        pre++;
      end else if (last_idx < 0) begin
        gaps++;
      end
      if (o_en != 0) begin
        en_val = o_en;
        en_idx = got_q.size() - 1;
        k = 0;
      end
      if (o_done != 0) begin
        done_val = o_done;
        done_dly = cyc - last_cyc;
        fin = 1;
      end
      if (scramble && !scr && got_q.size() == 1) begin
        dst = ~dst;
        et = ~et;
        scr = 1;
      end
      if (abort_at > 0 && got_q.size() == abort_at) begin
        rst = 1'b1;
        req_a = 2'b00;
        req_b = 2'b00;
        @(posedge clk);
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_trunc", o_trunc, 0);
        chk("rst_ch", o_ch, 0);
        chk("rst_en", o_en, 0);
        chk("rst_done", o_done, 0);
        rst = 1'b0;
        fin = 1;
      end
    end
    if (!fin) chk("timeout", 1, 0);
    chd = 16'h0000;
    chl = 2'b00;
  endtask

  task automatic check_frame(input string t, input int n, input int ch,
                             input int hl, input int trunc);
    int bad;
    bad = -1;
    chk({t, "_len"}, got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    chk({t, "_bad_byte_idx"}, bad, -1);
    chk({t, "_last_idx"}, last_idx, n - 1);
    chk({t, "_trunc_idx"}, trunc_idx, trunc);
    chk({t, "_done"}, done_val, 1 << ch);
    chk({t, "_done_dly"}, done_dly, 1);
    chk({t, "_gaps"}, gaps, 0);
    chk({t, "_ch"}, och, ch);
    chk({t, "_en"}, en_val, 1 << ch);
    chk({t, "_en_idx"}, en_idx, hl - 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tagx[6];
    int nd;
    checks = 0; errors = 0;
    sel = 0; req_a = 0; req_b = 0;
    dst = '0; et = '0; chd = '0; chl = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", o_vld, 0);
    chk("reset_data", o_data, 0);
    chk("reset_last", o_last, 0);
    chk("reset_trunc", o_trunc, 0);
    chk("reset_ch", o_ch, 0);
    chk("reset_en", o_en, 0);
    chk("reset_done", o_done, 0);
    rst = 1'b0;

    // broadcast ARP, 28-byte payload padded to 46
    dst[47:0] = 48'hFFFF_FFFF_FFFF;
    et[15:0]  = 16'h0806;
    build_exp(dst[47:0], et[15:0], 0, 28, 1);
    req_a = 2'b01;
    run_frame(0, 28, 1, 0, 0);
    req_a = 2'b00;
    chk("t1_latency", pre, 1);
    check_frame("t1", 60, 0, 14, -1);

    // both channels held: alternate 0,1,0,1 with 2 idle cycles
    do_reset();
    dst = {48'h0200_0000_00B1, 48'h0200_0000_00A0};
    et  = {16'h86DD, 16'h0800};
    req_a = 2'b11;
    for (int f = 0; f < 4; f++) begin
      build_exp(dst[48*(f%2) +: 48], et[16*(f%2) +: 16], 0, 46, 1);
      run_frame(f % 2, 46, 1, 0, 0);
      if (f == 3) req_a = 2'b00;
      check_frame("t2", 60, f % 2, 14, -1);
      if (f > 0) chk("t2_idle_gap", pre + 1, 2);
      else chk("t2_latency", pre, 1);
    end

    // VLAN instance, 10-byte payload
    sel = 1;
    dst[47:0] = 48'h0011_2233_4455;
    et[15:0]  = 16'h0800;
    build_exp(dst[47:0], et[15:0], 1, 10, 1);
    req_b = 2'b01;
    run_frame(0, 10, 1, 0, 0);
    req_b = 2'b00;
    check_frame("t3", 64, 0, 18, -1);
    tagx = '{8'h81, 8'h00, 8'h60, 8'h05, 8'h08, 8'h00};
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_byte%0d", 12 + i), got_q[12 + i], tagx[i]);

    // 100-byte payload, request fields changed mid-frame
    sel = 0;
    dst[47:0] = 48'h00AA_BBCC_DDEE;
    et[15:0]  = 16'h0800;
    build_exp(dst[47:0], et[15:0], 0, 100, 1);
    req_a = 2'b01;
    run_frame(0, 100, 1, 1, 0);
    req_a = 2'b00;
    check_frame("t4", 114, 0, 14, -1);

    // oversize payload without CH_LAST truncates at 1500
    dst[47:0] = 48'h00AA_BBCC_DDEE;
    et[15:0]  = 16'h0800;
    build_exp(dst[47:0], et[15:0], 0, 1600, 0);
    req_a = 2'b01;
    run_frame(0, 1600, 0, 0, 0);
    req_a = 2'b00;
    check_frame("t5", 1514, 0, 14, 1513);

    // reset at payload byte 10, then a clean ch1 frame
    req_a = 2'b01;
    run_frame(0, 60, 1, 0, 24);
    nd = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (o_done != 0) nd++;
    end
    chk("t6_no_done", nd, 0);
    dst[95:48] = 48'h0200_0000_00C1;
    et[31:16]  = 16'h0806;
    build_exp(dst[95:48], et[31:16], 0, 46, 1);
    req_a = 2'b10;
    run_frame(1, 46, 1, 0, 0);
    req_a = 2'b00;
    chk("t6_latency", pre, 1);
    check_frame("t6", 60, 1, 14, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
